// File: rtl/sw_debounce.sv
// Switch debouncer: two-flop synchroniser, stability counter and a STABLE/COUNT FSM
// that commits a debounced word to the CPU with a new_data/overrun handshake.
module sw_debounce #(
   parameter int WORD_W    = 8,
   parameter int DEB_COUNT = 50000,
   parameter int DEB_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WORD_W-1:0] sw_raw,
   input  logic              rd_ack,
   output logic [WORD_W-1:0] sw_out,
   output logic              new_data,
   output logic              overrun,
   output logic              busy
);

   typedef enum logic {ST_STABLE = 1'b0, ST_COUNT = 1'b1} state_t;

   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_COUNT - 1);

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   sync1_q, sync2_q;
   logic [WORD_W-1:0]   cand_q, cand_d;
   logic [DEB_W-1:0]    cnt_q, cnt_d;
   logic [WORD_W-1:0]   sw_out_q, sw_out_d;
   logic                new_data_q, new_data_d;
   logic                overrun_q, overrun_d;
   logic                busy_q, busy_d;
   logic                commit;

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_STABLE;
         sync1_q    <= '0;
         sync2_q    <= '0;
         cand_q     <= '0;
         cnt_q      <= '0;
         sw_out_q   <= '0;
         new_data_q <= 1'b0;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sw_raw;
         sync2_q    <= sync1_q;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         sw_out_q   <= sw_out_d;
         new_data_q <= new_data_d;
         overrun_q  <= overrun_d;
         busy_q     <= busy_d;
      end
   end

   // Next state: a change back to sw_out while counting is a rejected glitch
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         ST_STABLE: begin
            if (sync2_q != sw_out_q) begin
               cand_d  = sync2_q;
               cnt_d   = '0;
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (sync2_q != cand_q) begin
               cand_d  = sync2_q;
               cnt_d   = '0;
               state_d = (sync2_q == sw_out_q) ? ST_STABLE : ST_COUNT;
            end else if (cnt_q == CNT_LAST) begin
               commit  = 1'b1;
               cnt_d   = '0;
               state_d = ST_STABLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_STABLE;
      endcase
   end

   // Outputs: a commit outranks a coincident rd_ack
   always_comb begin
      sw_out_d   = commit ? cand_q : sw_out_q;
      new_data_d = new_data_q;
      overrun_d  = overrun_q;
      if (commit) begin
         new_data_d = 1'b1;
         if (new_data_q && !rd_ack)
            overrun_d = 1'b1;
      end else if (rd_ack && new_data_q) begin
         new_data_d = 1'b0;
         overrun_d  = 1'b0;
      end
      busy_d = (state_d == ST_COUNT);
   end

   assign sw_out   = sw_out_q;
   assign new_data = new_data_q;
   assign overrun  = overrun_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEB_COUNT=4: latency, glitch rejection,
// overrun, coincident ack and asynchronous reset during a count.
module tb_sw_debounce;

   localparam int WORD_W    = 8;
   localparam int DEB_COUNT = 4;
   localparam int DEB_W     = 16;
   localparam int LAT       = 2 + DEB_COUNT;

   logic              clock;
   logic              reset;
   logic [WORD_W-1:0] sw_raw;
   logic              rd_ack;
   logic [WORD_W-1:0] sw_out;
   logic              new_data;
   logic              overrun;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   sw_debounce #(.WORD_W(WORD_W), .DEB_COUNT(DEB_COUNT), .DEB_W(DEB_W)) dut (
      .clock    (clock),
      .reset    (reset),
      .sw_raw   (sw_raw),
      .rd_ack   (rd_ack),
      .sw_out   (sw_out),
      .new_data (new_data),
      .overrun  (overrun),
      .busy     (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Advance one rising edge and settle 1 time unit after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      step();
   endtask

   task automatic pulse_ack();
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
   endtask

   task automatic test_reset();
      sw_raw = 8'h00;
      rd_ack = 1'b0;
      reset  = 1'b1;
      #2;
      checks++;
      if ({sw_out, new_data, overrun, busy} !== 11'h000) begin
         failures++;
         $display("FAIL reset_values: actual sw_out=%h nd=%b ov=%b busy=%b required all 0",
                  sw_out, new_data, overrun, busy);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) step();
      checks++;
      if ({sw_out, new_data, overrun, busy} !== 11'h000) begin
         failures++;
         $display("FAIL reset_idle: actual sw_out=%h nd=%b ov=%b busy=%b required all 0",
                  sw_out, new_data, overrun, busy);
      end
   endtask

   task automatic test_latency();
      logic [WORD_W-1:0] exp_sw;
      logic              exp_busy;
      sw_raw = 8'hA5;
      for (int e = 0; e <= 7; e++) begin
         step();
         exp_sw   = (e >= LAT) ? 8'hA5 : 8'h00;
         exp_busy = (e >= 2 && e <= 5);
         checks++;
         if (sw_out !== exp_sw || new_data !== (e >= LAT) || busy !== exp_busy) begin
            failures++;
            $display("FAIL latency_edge%0d: actual sw_out=%h nd=%b busy=%b required sw_out=%h nd=%b busy=%b",
                     e, sw_out, new_data, busy, exp_sw, (e >= LAT), exp_busy);
         end
      end
      pulse_ack();
      checks++;
      if (sw_out !== 8'hA5 || new_data !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL ack_clears: actual sw_out=%h nd=%b ov=%b required A5 0 0",
                  sw_out, new_data, overrun);
      end
      pulse_ack();
      checks++;
      if (sw_out !== 8'hA5 || new_data !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL idle_ack: actual sw_out=%h nd=%b ov=%b required A5 0 0",
                  sw_out, new_data, overrun);
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      sw_raw = 8'h3C;
      step();
      step();
      sw_raw = 8'h00;
      step();
      step();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL glitch_busy: actual busy=%b required 1", busy);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (sw_out !== 8'h00 || new_data !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject%0d: actual sw_out=%h nd=%b busy=%b required 00 0 0",
                     i, sw_out, new_data, busy);
         end
      end
   endtask

   task automatic test_overrun();
      apply_reset();
      sw_raw = 8'h11;
      for (int i = 0; i <= LAT; i++) step();
      checks++;
      if (sw_out !== 8'h11 || new_data !== 1'b1 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL first_commit: actual sw_out=%h nd=%b ov=%b required 11 1 0",
                  sw_out, new_data, overrun);
      end
      sw_raw = 8'h22;
      for (int i = 0; i <= LAT; i++) step();
      checks++;
      if (sw_out !== 8'h22 || new_data !== 1'b1 || overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set: actual sw_out=%h nd=%b ov=%b required 22 1 1",
                  sw_out, new_data, overrun);
      end
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (overrun !== 1'b1 || new_data !== 1'b1) begin
         failures++;
         $display("FAIL overrun_sticky: actual nd=%b ov=%b required 1 1", new_data, overrun);
      end
      pulse_ack();
      checks++;
      if (sw_out !== 8'h22 || new_data !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_ack: actual sw_out=%h nd=%b ov=%b required 22 0 0",
                  sw_out, new_data, overrun);
      end
   endtask

   task automatic test_back_to_back();
      sw_raw = 8'h44;
      for (int i = 0; i <= LAT; i++) step();
      checks++;
      if (sw_out !== 8'h44 || new_data !== 1'b1 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL pre_coincide: actual sw_out=%h nd=%b ov=%b required 44 1 0",
                  sw_out, new_data, overrun);
      end
      sw_raw = 8'h55;
      for (int i = 0; i < LAT; i++) step();
      checks++;
      if (sw_out !== 8'h44 || busy !== 1'b1) begin
         failures++;
         $display("FAIL before_commit: actual sw_out=%h busy=%b required 44 1", sw_out, busy);
      end
      pulse_ack();
      checks++;
      if (sw_out !== 8'h55 || new_data !== 1'b1 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL coincident_ack: actual sw_out=%h nd=%b ov=%b required 55 1 0",
                  sw_out, new_data, overrun);
      end
      pulse_ack();
      checks++;
      if (new_data !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL post_coincide_ack: actual nd=%b ov=%b required 0 0", new_data, overrun);
      end
   endtask

   task automatic test_reset_mid_count();
      logic [WORD_W-1:0] exp_sw;
      apply_reset();
      sw_raw = 8'hFF;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (busy !== 1'b1 || sw_out !== 8'h00) begin
         failures++;
         $display("FAIL mid_count_busy: actual busy=%b sw_out=%h required 1 00", busy, sw_out);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({sw_out, new_data, overrun, busy} !== 11'h000) begin
         failures++;
         $display("FAIL async_reset: actual sw_out=%h nd=%b ov=%b busy=%b required all 0",
                  sw_out, new_data, overrun, busy);
      end
      #2;
      reset = 1'b0;
      for (int e = 0; e <= LAT + 1; e++) begin
         step();
         exp_sw = (e >= LAT) ? 8'hFF : 8'h00;
         checks++;
         if (sw_out !== exp_sw || new_data !== (e >= LAT)) begin
            failures++;
            $display("FAIL post_reset_edge%0d: actual sw_out=%h nd=%b required sw_out=%h nd=%b",
                     e, sw_out, new_data, exp_sw, (e >= LAT));
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_overrun();
      test_back_to_back();
      test_reset_mid_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WORD_W, default 8, SHALL set the width of the switch word delivered to the CPU input module.
REQ-002 Parameter DEB_COUNT, default 50000, SHALL set the consecutive stable cycles needed to accept a new value; legal range is 2 to 2**DEB_W-1.
REQ-003 Parameter DEB_W, default 16, SHALL set the stability counter width.
REQ-004 Ports SHALL be as follows; one clock; reset is asynchronous and active-high:
  clock     input   1       system clock, rising edge
  reset     input   1       asynchronous active-high reset
  sw_raw    input   WORD_W  unsynchronised board switches
  rd_ack    input   1       one-cycle pulse, CPU has consumed sw_out
  sw_out    output  WORD_W  debounced switch word, drives CPU sw
  new_data  output  1       sw_out committed and not yet acknowledged
  overrun   output  1       sticky: commit occurred while new_data already set
  busy      output  1       high while state is COUNT

Function
REQ-005 sw_raw SHALL pass through a two-flop synchroniser (sync1, then sync2) before any other use.
REQ-006 The block SHALL hold internal registers cand (WORD_W) and cnt (DEB_W), plus a two-state FSM with states STABLE and COUNT.
REQ-007 STABLE: if sync2 != sw_out, then cand <= sync2, cnt <= 0, next state COUNT; otherwise remain.
REQ-008 COUNT, sync2 != cand and sync2 == sw_out: cand <= sync2, cnt <= 0, next state STABLE, no commit (glitch rejected).
REQ-009 COUNT, sync2 != cand and sync2 != sw_out: cand <= sync2, cnt <= 0, remain in COUNT (restart).
REQ-010 COUNT, sync2 == cand and cnt < DEB_COUNT-1: cnt <= cnt+1.
REQ-011 COUNT, sync2 == cand and cnt == DEB_COUNT-1: commit; sw_out <= cand, cnt <= 0, next state STABLE.
REQ-012 Latency: sw_raw changed before edge k and held SHALL appear on sw_out immediately after edge k+2+DEB_COUNT.
REQ-013 cnt SHALL never exceed DEB_COUNT-1 and SHALL never wrap.
REQ-014 On commit, new_data SHALL be set; rd_ack without a commit SHALL clear new_data.
REQ-015 Simultaneous commit and rd_ack: new_data stays 1 and overrun is not set.
REQ-016 Commit with new_data==1 and no rd_ack SHALL set overrun; sw_out SHALL still take the new value.
REQ-017 overrun SHALL be cleared only by rd_ack in a cycle with no commit; otherwise it SHALL hold.
REQ-018 rd_ack with new_data==0 SHALL have no effect.
REQ-019 busy SHALL be a registered decode of the state: 1 in COUNT, 0 in STABLE.
REQ-020 All outputs SHALL be registered; there SHALL be no combinational path from sw_raw or rd_ack to any output.

Reset
REQ-021 On reset, asynchronously: sync1, sync2, cand, sw_out = 0; cnt = 0; new_data, overrun, busy = 0; state = STABLE.
REQ-022 Reset asserted in COUNT SHALL discard the pending candidate; no commit SHALL follow reset release unless a fresh full debounce completes.
REQ-023 After reset release with sw_raw held at 0, outputs SHALL stay at reset values indefinitely.

Verification (DEB_COUNT=4, WORD_W=8)
REQ-024 Setup: sw_raw 0x00 -> 0xA5 before edge 0, held. Required: sw_out 0xA5 and new_data=1 after edge 6; busy=1 from edge 2 through edge 5.
REQ-025 Glitch: sw_raw 0x00 -> 0x3C for 2 cycles, then back to 0x00. Required: sw_out stays 0x00, new_data=0, busy returns to 0.
REQ-026 Overrun: commit 0x11, no ack, then commit 0x22. Required: sw_out=0x22, new_data=1, overrun=1; next rd_ack clears both.
REQ-027 Coincident ack: rd_ack pulses on the same edge as the commit of 0x55. Required: new_data=1, overrun=0 after that edge.
REQ-028 Reset mid-count: reset asserted during COUNT, between edges, while sw_raw=0xFF. Required: all outputs 0 immediately without waiting for a clock edge. After release with 0xFF held, sw_out=0xFF only after 2+DEB_COUNT further edges.
